dual_port_ram: RTL and testbench

Simple dual-port synchronous RAM: one write port and one independent read port sharing a single clock. It serves as a generic on-chip buffer, for example behind FIFOs or packet staging logic. Writes and reads may occur in the same cycle. Read data is registered, and the whole array clears on reset.

---
 rtl/dual_port_ram_pkg.sv | 12 +
 rtl/dual_port_ram_if.sv | 29 ++
 rtl/dpr_mem_array.sv | 46 ++++
 rtl/dual_port_ram.sv | 65 ++++++
 tb/tb_dual_port_ram.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/dual_port_ram_pkg.sv
// Shared definitions for the dual-port RAM slice.
//   RAM_*_DEFAULT : default geometry used by the interface and top parameters
//   ram_word_t    : one data word at the default width
package dual_port_ram_pkg;

    localparam int RAM_WIDTH_DEFAULT = 8;
    localparam int ADDR_SIZE_DEFAULT = 4;
    localparam int RAM_DEPTH_DEFAULT = 16;

    typedef logic [RAM_WIDTH_DEFAULT-1:0] ram_word_t;

endpackage

// File: rtl/dual_port_ram_if.sv
// Bus bundle for the dual-port RAM: one write port, one read port.
//   data_in/wr_addr/write_en : write port (master -> slave)
//   rd_addr/read_en          : read request (master -> slave)
//   data_out                 : registered read data (slave -> master)
interface dual_port_ram_if
    import dual_port_ram_pkg::*;
#(
    parameter int ram_width = RAM_WIDTH_DEFAULT,
    parameter int addr_size = ADDR_SIZE_DEFAULT
);

    logic [ram_width-1:0] data_in;
    logic [addr_size-1:0] wr_addr;
    logic                 write_en;
    logic [addr_size-1:0] rd_addr;
    logic                 read_en;
    logic [ram_width-1:0] data_out;

    modport master (
        output data_in, wr_addr, write_en, rd_addr, read_en,
        input  data_out
    );

    modport slave (
        input  data_in, wr_addr, write_en, rd_addr, read_en,
        output data_out
    );

endinterface

// File: rtl/dpr_mem_array.sv
// Resettable register-array storage with write decode and a combinational
// read mux.
//   clk, reset : clock, async active-high clear of every word
//   we         : write strobe, already qualified as in range by the caller
//   wr_addr    : write address;  wr_data : write word
//   rd_addr    : read address;   rd_data : mem[rd_addr], 0 past the last word
module dpr_mem_array #(
    parameter int width     = 8,
    parameter int addr_size = 4,
    parameter int depth     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [addr_size-1:0] wr_addr,
    input  logic [width-1:0]     wr_data,
    input  logic [addr_size-1:0] rd_addr,
    output logic [width-1:0]     rd_data
);

    logic [depth-1:0][width-1:0] mem;

    for (genvar w = 0; w < depth; w++) begin : g_word
        localparam logic [addr_size-1:0] IDX = addr_size'(w);
        logic [width-1:0] word;

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                word <= '0;
            else if (we && wr_addr == IDX)
                word <= wr_data;
        end

        assign mem[w] = word;
    end

    // Compare-and-select instead of mem[rd_addr] so an address past the
    // last word never indexes outside the array.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < depth; i++)
            if (rd_addr == addr_size'(i))
                rd_data = mem[i];
    end

endmodule

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM: independent write and read ports on one
// clock, registered read data, whole array cleared by reset.
//   clk   : clock, all state changes on its rising edge
//   reset : async active-high, clears data_out and every word
//   bus   : dual_port_ram_if slave (write port, read port, data_out)
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int ram_width = RAM_WIDTH_DEFAULT,
    parameter int addr_size = ADDR_SIZE_DEFAULT,
    parameter int ram_depth = RAM_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    dual_port_ram_if.slave  bus
);

    if (ram_depth > 2**addr_size) begin : g_bad_depth
        $error("dual_port_ram: ram_depth exceeds 2**addr_size");
    end

    // One extra bit so depth == 2**addr_size is representable.
    localparam logic [addr_size:0] DEPTH_L = (addr_size+1)'(ram_depth);

    logic                 wr_ok;
    logic                 rd_ok;
    logic                 wr_hit;
    logic [ram_width-1:0] rd_word;
    logic [ram_width-1:0] data_q;

    assign wr_ok  = {1'b0, bus.wr_addr} < DEPTH_L;
    assign rd_ok  = {1'b0, bus.rd_addr} < DEPTH_L;
    // Same-cycle write to the word being read: return the new data.
    assign wr_hit = bus.write_en && wr_ok && (bus.wr_addr == bus.rd_addr);

    dpr_mem_array #(
        .width     (ram_width),
        .addr_size (addr_size),
        .depth     (ram_depth)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.write_en && wr_ok),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.data_in),
        .rd_addr (bus.rd_addr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_q <= '0;
        else if (bus.read_en) begin
            if (!rd_ok)
                data_q <= '0;
            else if (wr_hit)
                data_q <= bus.data_in;
            else
                data_q <= rd_word;
        end
    end

    assign bus.data_out = data_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Self-checking bench for dual_port_ram: table-driven vectors whose expected
// read data is queued when the read is driven and compared one edge later.
// Uses a 5-bit address with 16 words so out-of-range accesses are reachable.
module tb_dual_port_ram;
    import dual_port_ram_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 16;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        ram_word_t     din;
        logic          re;
        logic [AW-1:0] ra;
        ram_word_t     exp;
    } vec_t;

    logic clk;
    logic reset;

    dual_port_ram_if #(.ram_width(8), .addr_size(AW)) bus ();

    dual_port_ram #(.ram_width(8), .addr_size(AW), .ram_depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int        n_checks = 0;
    int        n_fail   = 0;
    ram_word_t exp_q[$];
    vec_t      vecs[$];

    task automatic check(input string name, input ram_word_t act, input ram_word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: data_out=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(logic we, int wa, int din, logic re, int ra, int ex);
        vec_t v;
        v.we  = we;
        v.wa  = AW'(wa);
        v.din = 8'(din);
        v.re  = re;
        v.ra  = AW'(ra);
        v.exp = 8'(ex);
        return v;
    endfunction

    // Drive one cycle of stimulus, then compare any read result after the edge.
    task automatic step(input vec_t v, input string name);
        bus.write_en = v.we;
        bus.wr_addr  = v.wa;
        bus.data_in  = v.din;
        bus.read_en  = v.re;
        bus.rd_addr  = v.ra;
        if (v.re) exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        if (v.re) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                check(name, bus.data_out, exp_q.pop_front());
            end
        end
    endtask

    task automatic run_vecs(input string tag);
        for (int k = 0; k < vecs.size(); k++)
            step(vecs[k], $sformatf("%s[%0d]", tag, k));
        vecs.delete();
    endtask

    task automatic idle();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        bus.data_in  = '0;
        bus.wr_addr  = '0;
        bus.write_en = 1'b0;
        bus.rd_addr  = '0;
        bus.read_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", bus.data_out, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Post-reset contents are all zero.
        for (int a = 0; a < DEPTH; a++) vecs.push_back(mkv(0, 0, 0, 1, a, 0));
        run_vecs("reset_read");

        // Fill: data i at address i-1, then read back up to address 5.
        for (int i = 1; i <= DEPTH; i++) vecs.push_back(mkv(1, i - 1, i, 0, 0, 0));
        for (int a = 0; a <= 5; a++) vecs.push_back(mkv(0, 0, 0, 1, a, a + 1));
        run_vecs("fill_read");

        // Hold: read_en low with a moving address keeps the last value.
        idle();
        bus.rd_addr = AW'(9);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("hold", bus.data_out, 8'h06);
        end

        for (int a = 6; a < DEPTH; a++) vecs.push_back(mkv(0, 0, 0, 1, a, a + 1));
        // Write-first collision, then the stored value persists.
        vecs.push_back(mkv(1, 3, 'hA5, 1, 3, 'hA5));
        vecs.push_back(mkv(0, 0, 0, 1, 3, 'hA5));
        // Parallel ports on different addresses.
        vecs.push_back(mkv(1, 10, 'h3C, 1, 2, 3));
        vecs.push_back(mkv(0, 0, 0, 1, 10, 'h3C));
        vecs.push_back(mkv(1, 15, 'hEE, 1, 14, 15));
        vecs.push_back(mkv(0, 0, 0, 1, 15, 'hEE));
        // Out-of-range write ignored (no alias onto word 0), read returns 0.
        vecs.push_back(mkv(1, 16, 'h77, 1, 0, 1));
        vecs.push_back(mkv(1, 31, 'h55, 1, 16, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 31, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 15, 'hEE));
        // Out-of-range read while an in-range write to the same low bits occurs.
        vecs.push_back(mkv(1, 0, 'h99, 1, 16, 0));
        vecs.push_back(mkv(0, 0, 0, 1, 0, 'h99));
        run_vecs("main");

        // Mid-operation reset during a refill with same-cycle reads.
        for (int k = 0; k < 4; k++) vecs.push_back(mkv(1, k, 'h40 + k, 1, k, 'h40 + k));
        run_vecs("refill");
        bus.write_en = 1'b1;
        bus.wr_addr  = AW'(4);
        bus.data_in  = 8'h44;
        bus.read_en  = 1'b1;
        bus.rd_addr  = AW'(1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_dout", bus.data_out, 8'h00);
        idle();
        #2;
        reset = 1'b0;
        for (int a = 0; a < DEPTH; a++) vecs.push_back(mkv(0, 0, 0, 1, a, 0));
        run_vecs("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
